multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the 32-bit multicycle MIPS core. It sits directly upstream of the datapath. From the datapath it consumes `op`, `funct` and `zero`, and it drives the 15-bit `control_bus` that the datapath unpacks every cycle. The block holds a 12-state main FSM that sequences each instruction over 3–5 cycles, plus a combinational ALU decoder.

## Interface
Parameters: none. All encodings are fixed by the datapath bus layout.

- `clk` input 1: single system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `op` input 6: `instr[31:26]` from the datapath instruction register.
- `funct` input 6: `instr[5:0]`; used only for R-type.
- `zero` input 1: live ALU zero flag, combinational from the datapath.
- `control_bus` output 15, packed MSB to LSB:
  - `{IorD, MemWrite, IRWrite, PCEn, ALUSrcA, RegWrite, RegDst, MemtoReg, PCSrc[1:0], ALUSrcB[1:0], ALUControl[2:0]}`
  - IorD is bit 14; ALUControl is bits 2:0.
- `state` output 4: current FSM state, for debug and the bench.

## Operation
- Supported opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- Any other opcode: DECODE goes to FETCH; the instruction is a 2-cycle NOP.
- Outputs are Moore from `state`. The only exception is PCEn, computed as `PCEn = PCWrite | (Branch & zero)`.
- Every field not listed for a state is 0. ALUOp defaults to 00.
- Per-state outputs:
  - FETCH (0): IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD (3): IorD=1.
  - MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR (5): IorD=1, MemWrite=1.
  - EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB (7): RegDst=1, MemtoReg=0, RegWrite=1.
  - BEQ (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEXEC (9): ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB (10): RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP (11): PCSrc=10, PCWrite=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXECUTE (R), BEQ, ADDIEXEC, JUMP, else FETCH.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB.
  - EXECUTE→ALUWB.
  - ADDIEXEC→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BEQ, ADDIWB, JUMP→FETCH.
  - Encodings 12–15 are illegal and go to FETCH on the next edge; their outputs are the reset value.
- ALU decoder, ALUControl from ALUOp/funct:
  - ALUOp 00 → 010 (add).
  - ALUOp 01 → 110 (sub).
  - ALUOp 10 with funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - ALUOp 10 with any other funct → 010.
  - ALUOp 11 → 010.

## Timing
- While `reset` is high:
  - `state` = FETCH.
  - `control_bus` = 15'h0002: all enables 0, ALUControl = add.
  - Forcing applies combinationally, so no PC, IR, register or memory write occurs during reset.
- First rising edge after reset deassertion: the FETCH step commits. FETCH bus = 15'h180A.
- Reset mid-instruction: the FSM returns to FETCH immediately (asynchronous). Pending writes are suppressed from the assertion instant.
- Cycles per instruction, FETCH inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - unknown 2
- `op`/`funct` are sampled combinationally in DECODE; IR is stable from FETCH's edge onward.
- `zero` is used only in BEQ, within the same cycle; there is no internal registering of `zero`.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - `state_t` enum with the 4-bit encodings above.
  - Opcode and funct constants.
  - ALUOp codes.
  - ALUControl codes.
  - Bus bit-position localparams, shared with the datapath.
- Sub-module `alu_decoder` takes ALUOp and funct and produces ALUControl; it is purely combinational.
- Top level contains the state register (async reset), next-state logic, the output decode, and the PCEn/reset gating.

## Test plan
- Reset held 3 cycles, then released with op=100011 → during reset bus=15'h0002, state=0. Then states 0,1,2,3,4,0. MEMWB bus has RegWrite=1 and MemtoReg=1.
- R-type op=000000, funct=101010 → states 0,1,6,7,0. EXECUTE bus ALUControl=111, ALUSrcA=1. ALUWB bus RegDst=1.
- beq op=000100 in BEQ state: zero=1 → bus=15'h0C26 (PCEn=1); zero=0 → bus=15'h0426. Next state FETCH either way.
- sw op=101011 → states 0,1,2,5,0. MEMWR bus has IorD=1 and MemWrite=1, and only those bits set besides ALUControl=010.
- j op=000010 → JUMP bus has PCSrc=10 and PCEn=1. Unknown op=111111 → DECODE goes to FETCH.
- Reset asserted asynchronously mid-cycle in MEMWB → bus drops to 15'h0002 before the next edge. `state`=0, and RegWrite is never sampled high at that edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// ALU operation codes and the control-bus bit layout used by the datapath.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    localparam int unsigned BUS_W          = 15;
    localparam int unsigned BUS_IORD       = 14;
    localparam int unsigned BUS_MEMWRITE   = 13;
    localparam int unsigned BUS_IRWRITE    = 12;
    localparam int unsigned BUS_PCEN       = 11;
    localparam int unsigned BUS_ALUSRCA    = 10;
    localparam int unsigned BUS_REGWRITE   = 9;
    localparam int unsigned BUS_REGDST     = 8;
    localparam int unsigned BUS_MEMTOREG   = 7;
    localparam int unsigned BUS_PCSRC_MSB  = 6;
    localparam int unsigned BUS_ALUSRCB_MSB = 4;
    localparam int unsigned BUS_ALUCTL_MSB = 2;

    // All enables low, ALU left on add.
    localparam logic [BUS_W-1:0] RESET_BUS = 15'h0002;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and R-type funct to ALUControl.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALUCTL_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALUCTL_ADD;
                    FUNCT_SUB: alu_control = ALUCTL_SUB;
                    FUNCT_AND: alu_control = ALUCTL_AND;
                    FUNCT_OR:  alu_control = ALUCTL_OR;
                    FUNCT_SLT: alu_control = ALUCTL_SLT;
                    default:   alu_control = ALUCTL_ADD;
                endcase
            end
            default: alu_control = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: 12-state Moore FSM driving the packed
// datapath control bus, with PCEn as the only zero-dependent output.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    output logic [BUS_W-1:0]     control_bus,
    output logic [3:0]           state
);

    state_t state_q;
    state_t state_d;

    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       pcen;
    logic       alusrca;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [2:0] alu_control;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore field decode; unlisted fields stay at their zero default.
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        alusrca  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        pcsrc    = 2'b00;
        alusrcb  = 2'b00;
        aluop    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQ: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (funct),
        .alu_control (alu_control)
    );

    always_comb begin
        pcen = pcwrite | (branch & zero);
        control_bus = '0;
        control_bus[BUS_IORD]     = iord;
        control_bus[BUS_MEMWRITE] = memwrite;
        control_bus[BUS_IRWRITE]  = irwrite;
        control_bus[BUS_PCEN]     = pcen;
        control_bus[BUS_ALUSRCA]  = alusrca;
        control_bus[BUS_REGWRITE] = regwrite;
        control_bus[BUS_REGDST]   = regdst;
        control_bus[BUS_MEMTOREG] = memtoreg;
        control_bus[BUS_PCSRC_MSB -: 2]   = pcsrc;
        control_bus[BUS_ALUSRCB_MSB -: 2] = alusrcb;
        control_bus[BUS_ALUCTL_MSB -: 3]  = alu_control;
        // Gate combinationally so writes are suppressed from the reset instant.
        if (reset) control_bus = RESET_BUS;
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes hand-computed
// {state, bus} expectations, a monitor pops and compares them off-edge.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [14:0] control_bus;
    logic [3:0]  state;

    typedef struct {
        string       name;
        logic [3:0]  s;
        logic [14:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic chk_tgl = 1'b0;

    multicycle_controller dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .control_bus (control_bus),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Monitor: compares at every falling edge, or on demand for mid-cycle checks.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_tgl);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (state !== e.s || control_bus !== e.b) begin
                    bad++;
                    $display("FAIL %s: got state=%0d bus=%h, expected state=%0d bus=%h",
                             e.name, state, control_bus, e.s, e.b);
                end
            end
        end
    end

    task automatic step(input string nm, input logic rst_i, input logic [5:0] op_i,
                        input logic [5:0] funct_i, input logic zero_i,
                        input logic [3:0] s, input logic [14:0] b);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_i;
        op    = op_i;
        funct = funct_i;
        zero  = zero_i;
        e.name = nm; e.s = s; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic now_chk(input string nm, input logic [3:0] s, input logic [14:0] b);
        exp_t e;
        #1;
        e.name = nm; e.s = s; e.b = b;
        exp_q.push_back(e);
        chk_tgl = ~chk_tgl;
    endtask

    logic [5:0]  fn_tab  [5] = '{6'b101010, 6'b100010, 6'b100100, 6'b100101, 6'b000000};
    logic [14:0] exe_tab [5] = '{15'h0407, 15'h0406, 15'h0400, 15'h0401, 15'h0402};

    initial begin
        reset = 1'b1;
        op    = 6'b100011;
        funct = 6'b0;
        zero  = 1'b0;

        repeat (3) step("reset_hold", 1'b1, 6'b100011, 6'b0, 1'b0, 4'd0, 15'h0002);

        // lw: 5 cycles
        step("lw_fetch",  1'b0, 6'b100011, 6'b0, 1'b0, 4'd0, 15'h180A);
        step("lw_decode", 1'b0, 6'b100011, 6'b0, 1'b0, 4'd1, 15'h001A);
        step("lw_memadr", 1'b0, 6'b100011, 6'b0, 1'b0, 4'd2, 15'h0412);
        step("lw_memrd",  1'b0, 6'b100011, 6'b0, 1'b0, 4'd3, 15'h4002);
        step("lw_memwb",  1'b0, 6'b100011, 6'b0, 1'b0, 4'd4, 15'h0282);

        // R-type across several functs, including an unknown one
        for (int i = 0; i < 5; i++) begin
            step("r_fetch",   1'b0, 6'b000000, fn_tab[i], 1'b0, 4'd0, 15'h180A);
            step("r_decode",  1'b0, 6'b000000, fn_tab[i], 1'b0, 4'd1, 15'h001A);
            step("r_execute", 1'b0, 6'b000000, fn_tab[i], 1'b0, 4'd6, exe_tab[i]);
            step("r_aluwb",   1'b0, 6'b000000, fn_tab[i], 1'b0, 4'd7, 15'h0302);
        end

        // beq: zero=1 then zero=0 within the same BEQ cycle
        step("beq_fetch",  1'b0, 6'b000100, 6'b0, 1'b0, 4'd0, 15'h180A);
        step("beq_decode", 1'b0, 6'b000100, 6'b0, 1'b0, 4'd1, 15'h001A);
        step("beq_taken",  1'b0, 6'b000100, 6'b0, 1'b1, 4'd8, 15'h0C26);
        @(negedge clk);
        #1 zero = 1'b0;
        now_chk("beq_nottaken", 4'd8, 15'h0426);

        // sw: 4 cycles
        step("sw_fetch",  1'b0, 6'b101011, 6'b0, 1'b0, 4'd0, 15'h180A);
        step("sw_decode", 1'b0, 6'b101011, 6'b0, 1'b0, 4'd1, 15'h001A);
        step("sw_memadr", 1'b0, 6'b101011, 6'b0, 1'b0, 4'd2, 15'h0412);
        step("sw_memwr",  1'b0, 6'b101011, 6'b0, 1'b0, 4'd5, 15'h6002);

        // addi: 4 cycles
        step("addi_fetch",  1'b0, 6'b001000, 6'b0, 1'b0, 4'd0,  15'h180A);
        step("addi_decode", 1'b0, 6'b001000, 6'b0, 1'b0, 4'd1,  15'h001A);
        step("addi_exec",   1'b0, 6'b001000, 6'b0, 1'b0, 4'd9,  15'h0412);
        step("addi_wb",     1'b0, 6'b001000, 6'b0, 1'b0, 4'd10, 15'h0202);

        // j: 3 cycles
        step("j_fetch",  1'b0, 6'b000010, 6'b0, 1'b0, 4'd0,  15'h180A);
        step("j_decode", 1'b0, 6'b000010, 6'b0, 1'b0, 4'd1,  15'h001A);
        step("j_jump",   1'b0, 6'b000010, 6'b0, 1'b1, 4'd11, 15'h0842);

        // unknown opcode: 2-cycle NOP
        step("unk_fetch",  1'b0, 6'b111111, 6'b0, 1'b0, 4'd0, 15'h180A);
        step("unk_decode", 1'b0, 6'b111111, 6'b0, 1'b0, 4'd1, 15'h001A);

        // lw again, with asynchronous reset in the middle of MEMWB
        step("lw2_fetch",  1'b0, 6'b100011, 6'b0, 1'b0, 4'd0, 15'h180A);
        step("lw2_decode", 1'b0, 6'b100011, 6'b0, 1'b0, 4'd1, 15'h001A);
        step("lw2_memadr", 1'b0, 6'b100011, 6'b0, 1'b0, 4'd2, 15'h0412);
        step("lw2_memrd",  1'b0, 6'b100011, 6'b0, 1'b0, 4'd3, 15'h4002);
        step("lw2_memwb",  1'b0, 6'b100011, 6'b0, 1'b0, 4'd4, 15'h0282);
        @(negedge clk);
        #2 reset = 1'b1;
        now_chk("async_reset", 4'd0, 15'h0002);
        step("reset_edge", 1'b1, 6'b100011, 6'b0, 1'b0, 4'd0, 15'h0002);
        step("post_fetch",  1'b0, 6'b000000, 6'b100000, 1'b0, 4'd0, 15'h180A);
        step("post_decode", 1'b0, 6'b000000, 6'b100000, 1'b0, 4'd1, 15'h001A);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d unchecked expectations, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // RegWrite must never be seen high at a clock edge while reset is asserted.
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            total++;
            if (control_bus[9] !== 1'b0) begin
                bad++;
                $display("FAIL regwrite_in_reset: got %b, expected 0", control_bus[9]);
            end
        end
    end

endmodule
